// File: rtl/parser_rule_cfg_if.sv
// ============================================================================
// Module : parser_rule_cfg_if
// Desc   : Config word stream, rule write bus and status for parser_rule_cfg.
//          Readback signals are present only when PARSER_CFG_READBACK_EN is defined.
// Rev    : 1.0
// ============================================================================
`default_nettype none

interface parser_rule_cfg_if #(
  parameter int RULE_NUM         = 8,
  parameter int TYPE_NUM         = 2,
  parameter int TYPE_WIDTH       = 16,
  parameter int KEY_FILED_NUM    = 4,
  parameter int KEY_OFFSET_WIDTH = 6,
  parameter int HEAD_SHIFT_WIDTH = 6,
  parameter int META_SHIFT_WIDTH = 8,
  parameter int CFG_WIDTH        = 32
);
  logic                                      i_cfg_valid;
  logic                                      o_cfg_ready;
  logic [CFG_WIDTH-1:0]                      i_cfg_data;
  logic [RULE_NUM-1:0]                       o_rule_wren;
  logic                                      o_typeRule_valid;
  logic [TYPE_NUM*TYPE_WIDTH-1:0]            o_typeRule_typeData;
  logic [TYPE_NUM*TYPE_WIDTH-1:0]            o_typeRule_typeMask;
  logic [KEY_FILED_NUM*KEY_OFFSET_WIDTH-1:0] o_typeRule_keyOffset;
  logic [HEAD_SHIFT_WIDTH-1:0]               o_typeRule_headShift;
  logic [META_SHIFT_WIDTH-1:0]               o_typeRule_metaShift;
  logic [RULE_NUM-1:0]                       o_rule_valid_map;
  logic                                      o_done;
  logic                                      o_err;
`ifdef PARSER_CFG_READBACK_EN
  logic                                      o_rd_valid;
  logic                                      i_rd_ready;
  logic [CFG_WIDTH-1:0]                      o_rd_data;

  modport slave (
    input  i_cfg_valid, i_cfg_data, i_rd_ready,
    output o_cfg_ready, o_rule_wren, o_typeRule_valid, o_typeRule_typeData,
           o_typeRule_typeMask, o_typeRule_keyOffset, o_typeRule_headShift,
           o_typeRule_metaShift, o_rule_valid_map, o_done, o_err,
           o_rd_valid, o_rd_data
  );
  modport master (
    output i_cfg_valid, i_cfg_data, i_rd_ready,
    input  o_cfg_ready, o_rule_wren, o_typeRule_valid, o_typeRule_typeData,
           o_typeRule_typeMask, o_typeRule_keyOffset, o_typeRule_headShift,
           o_typeRule_metaShift, o_rule_valid_map, o_done, o_err,
           o_rd_valid, o_rd_data
  );
`else
  modport slave (
    input  i_cfg_valid, i_cfg_data,
    output o_cfg_ready, o_rule_wren, o_typeRule_valid, o_typeRule_typeData,
           o_typeRule_typeMask, o_typeRule_keyOffset, o_typeRule_headShift,
           o_typeRule_metaShift, o_rule_valid_map, o_done, o_err
  );
  modport master (
    output i_cfg_valid, i_cfg_data,
    input  o_cfg_ready, o_rule_wren, o_typeRule_valid, o_typeRule_typeData,
           o_typeRule_typeMask, o_typeRule_keyOffset, o_typeRule_headShift,
           o_typeRule_metaShift, o_rule_valid_map, o_done, o_err
  );
`endif
endinterface

`default_nettype wire

// File: rtl/parser_rule_cfg.sv
// ============================================================================
// Module : parser_rule_cfg
// Desc   : Assembles rule records from a config word stream and issues a
//          one-hot rule write pulse. Readback: define PARSER_CFG_READBACK_EN.
// Rev    : 1.0
// ============================================================================
`default_nettype none

module parser_rule_cfg #(
  parameter int RULE_NUM         = 8,
  parameter int TYPE_NUM         = 2,
  parameter int TYPE_WIDTH       = 16,
  parameter int KEY_FILED_NUM    = 4,
  parameter int KEY_OFFSET_WIDTH = 6,
  parameter int HEAD_SHIFT_WIDTH = 6,
  parameter int META_SHIFT_WIDTH = 8,
  parameter int CFG_WIDTH        = 32
) (
  input  logic            i_clk,
  input  logic            i_rst,
  parser_rule_cfg_if.slave cfg
);
  localparam int TB_W      = TYPE_NUM * TYPE_WIDTH;
  localparam int KO_W      = KEY_FILED_NUM * KEY_OFFSET_WIDTH;
  localparam int RULE_BITS = 1 + 2 * TB_W + KO_W + HEAD_SHIFT_WIDTH + META_SHIFT_WIDTH;
  localparam int WORDS     = (RULE_BITS + CFG_WIDTH - 1) / CFG_WIDTH;
  localparam int BUF_W     = WORDS * CFG_WIDTH;
  localparam int CNT_W     = (WORDS > 1) ? $clog2(WORDS) : 1;
  localparam int OFF_TD    = 1;
  localparam int OFF_TM    = OFF_TD + TB_W;
  localparam int OFF_KO    = OFF_TM + TB_W;
  localparam int OFF_HS    = OFF_KO + KO_W;
  localparam int OFF_MS    = OFF_HS + HEAD_SHIFT_WIDTH;

  localparam logic [1:0] OP_WRITE = 2'd0;
  localparam logic [1:0] OP_CLEAR = 2'd1;
  localparam logic [1:0] OP_READ  = 2'd2;

`ifdef PARSER_CFG_READBACK_EN
  localparam int IDX_W = (RULE_NUM > 1) ? $clog2(RULE_NUM) : 1;
  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_LOAD   = 3'd1,
    S_COMMIT = 3'd2,
    S_CLEAR  = 3'd3,
    S_READ   = 3'd4
  } state_t;
`else
  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_LOAD   = 2'd1,
    S_COMMIT = 2'd2,
    S_CLEAR  = 2'd3
  } state_t;
`endif

  state_t               state_q, state_d;
  logic [CNT_W-1:0]     cnt_q, cnt_d;
  logic [7:0]           idx_q, idx_d;
  logic [BUF_W-1:0]     buf_q, buf_d;
  logic [RULE_BITS-1:0] rule_q, rule_d;
  logic [RULE_NUM-1:0]  map_q, map_d;
  logic                 err_q, err_d;

  logic                 w_ready;
  logic                 w_xfer;
  logic                 w_hdr_in_range;
  logic                 w_in_range;
  logic [RULE_NUM-1:0]  w_hit;
  logic [RULE_NUM-1:0]  w_wren;
  logic                 w_done;
  logic                 w_commit_err;

  for (genvar gi = 0; gi < RULE_NUM; gi++) begin : g_hit
    assign w_hit[gi] = (idx_q == 8'(gi));
  end

  assign w_in_range     = |w_hit;
  assign w_hdr_in_range = ({1'b0, cfg.i_cfg_data[15:8]} < 9'(RULE_NUM));
  assign w_ready        = !i_rst && ((state_q == S_IDLE) || (state_q == S_LOAD));
  assign w_xfer         = cfg.i_cfg_valid && w_ready;

`ifdef PARSER_CFG_READBACK_EN
  logic [RULE_BITS-1:0] shadow_q [RULE_NUM];
  logic                 rd_done_q, rd_done_d;
  logic [BUF_W-1:0]     w_rd_buf;
  logic                 w_rd_valid;
  logic [CFG_WIDTH-1:0] w_rd_data;

  assign w_rd_buf = BUF_W'(shadow_q[idx_q[IDX_W-1:0]]);
`endif

  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    idx_d        = idx_q;
    buf_d        = buf_q;
    rule_d       = rule_q;
    map_d        = map_q;
    err_d        = 1'b0;
    w_wren       = '0;
    w_done       = 1'b0;
    w_commit_err = 1'b0;
`ifdef PARSER_CFG_READBACK_EN
    rd_done_d    = 1'b0;
    w_rd_valid   = 1'b0;
    w_rd_data    = '0;
`endif
    unique case (state_q)
      S_IDLE: begin
        if (w_xfer) begin
          idx_d = cfg.i_cfg_data[15:8];
          cnt_d = '0;
          case (cfg.i_cfg_data[1:0])
            OP_WRITE: state_d = S_LOAD;
            OP_CLEAR: begin
              state_d = S_CLEAR;
              rule_d  = '0;
            end
`ifdef PARSER_CFG_READBACK_EN
            OP_READ: begin
              if (w_hdr_in_range) state_d = S_READ;
              else                err_d   = 1'b1;
            end
`else
            OP_READ:  err_d = 1'b1;
`endif
            default:  err_d = 1'b1;
          endcase
        end
      end
      S_LOAD: begin
        if (w_xfer) begin
          buf_d[cnt_q*CFG_WIDTH +: CFG_WIDTH] = cfg.i_cfg_data;
          cnt_d = cnt_q + CNT_W'(1);
          if (cnt_q == CNT_W'(WORDS - 1)) begin
            state_d = S_COMMIT;
            rule_d  = buf_d[RULE_BITS-1:0];
          end
        end
      end
      S_COMMIT: begin
        w_wren = w_hit;
        if (w_in_range) begin
          w_done = 1'b1;
          map_d  = rule_q[0] ? (map_q | w_hit) : (map_q & ~w_hit);
        end else begin
          w_commit_err = 1'b1;
        end
        state_d = S_IDLE;
      end
      S_CLEAR: begin
        w_wren  = '1;
        w_done  = 1'b1;
        map_d   = '0;
        state_d = S_IDLE;
      end
`ifdef PARSER_CFG_READBACK_EN
      S_READ: begin
        w_rd_valid = 1'b1;
        w_rd_data  = w_rd_buf[cnt_q*CFG_WIDTH +: CFG_WIDTH];
        if (cfg.i_rd_ready) begin
          cnt_d = cnt_q + CNT_W'(1);
          if (cnt_q == CNT_W'(WORDS - 1)) begin
            state_d   = S_IDLE;
            rd_done_d = 1'b1;
          end
        end
      end
`endif
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      idx_q   <= '0;
      buf_q   <= '0;
      rule_q  <= '0;
      map_q   <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      idx_q   <= idx_d;
      buf_q   <= buf_d;
      rule_q  <= rule_d;
      map_q   <= map_d;
      err_q   <= err_d;
    end
  end

`ifdef PARSER_CFG_READBACK_EN
  // Shadow mirrors exactly what the lookup tables received.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      rd_done_q <= 1'b0;
      for (int i = 0; i < RULE_NUM; i++) shadow_q[i] <= '0;
    end else begin
      rd_done_q <= rd_done_d;
      if (state_q == S_CLEAR) begin
        for (int i = 0; i < RULE_NUM; i++) shadow_q[i] <= '0;
      end else if ((state_q == S_COMMIT) && w_in_range) begin
        shadow_q[idx_q[IDX_W-1:0]] <= rule_q;
      end
    end
  end

  assign cfg.o_rd_valid = w_rd_valid;
  assign cfg.o_rd_data  = w_rd_data;
  assign cfg.o_done     = w_done | rd_done_q;
`else
  assign cfg.o_done     = w_done;
`endif

  assign cfg.o_cfg_ready          = w_ready;
  assign cfg.o_rule_wren          = w_wren;
  assign cfg.o_err                = err_q | w_commit_err;
  assign cfg.o_rule_valid_map     = map_q;
  assign cfg.o_typeRule_valid     = rule_q[0];
  assign cfg.o_typeRule_typeData  = rule_q[OFF_TD +: TB_W];
  assign cfg.o_typeRule_typeMask  = rule_q[OFF_TM +: TB_W];
  assign cfg.o_typeRule_keyOffset = rule_q[OFF_KO +: KO_W];
  assign cfg.o_typeRule_headShift = rule_q[OFF_HS +: HEAD_SHIFT_WIDTH];
  assign cfg.o_typeRule_metaShift = rule_q[OFF_MS +: META_SHIFT_WIDTH];

endmodule

`default_nettype wire

// File: tb/tb_parser_rule_cfg.sv
// ============================================================================
// Module : tb_parser_rule_cfg
// Desc   : Scoreboard bench for parser_rule_cfg; readback path covered when
//          PARSER_CFG_READBACK_EN is defined.
// Rev    : 1.0
// ============================================================================
`default_nettype none

module tb_parser_rule_cfg;
  localparam int RULE_NUM = 8, TYPE_NUM = 2, TYPE_WIDTH = 16, KEY_FILED_NUM = 4;
  localparam int KEY_OFFSET_WIDTH = 6, HEAD_SHIFT_WIDTH = 6, META_SHIFT_WIDTH = 8, CFG_WIDTH = 32;
  localparam int TD_W = TYPE_NUM * TYPE_WIDTH;
  localparam int KO_W = KEY_FILED_NUM * KEY_OFFSET_WIDTH;
  localparam int RULE_BITS = 1 + 2 * TD_W + KO_W + HEAD_SHIFT_WIDTH + META_SHIFT_WIDTH;
  localparam int WORDS = (RULE_BITS + CFG_WIDTH - 1) / CFG_WIDTH;
  localparam int BUF_W = WORDS * CFG_WIDTH;

  typedef struct packed {
    logic [META_SHIFT_WIDTH-1:0] ms;
    logic [HEAD_SHIFT_WIDTH-1:0] hs;
    logic [KO_W-1:0]             ko;
    logic [TD_W-1:0]             tm;
    logic [TD_W-1:0]             td;
    logic                        v;
  } rule_t;

  typedef struct {
    int                  cyc;
    logic [RULE_NUM-1:0] wren;
    logic                done;
    logic                err;
    rule_t               f;
  } ev_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   cyc = 0;
  int   checks = 0;
  int   errors = 0;
  ev_t  exp_q[$];
  rule_t               cur;
  rule_t               tab [RULE_NUM];
  logic [RULE_NUM-1:0] map_m;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  parser_rule_cfg_if #(
    .RULE_NUM(RULE_NUM), .TYPE_NUM(TYPE_NUM), .TYPE_WIDTH(TYPE_WIDTH),
    .KEY_FILED_NUM(KEY_FILED_NUM), .KEY_OFFSET_WIDTH(KEY_OFFSET_WIDTH),
    .HEAD_SHIFT_WIDTH(HEAD_SHIFT_WIDTH), .META_SHIFT_WIDTH(META_SHIFT_WIDTH),
    .CFG_WIDTH(CFG_WIDTH)
  ) bus ();

  parser_rule_cfg #(
    .RULE_NUM(RULE_NUM), .TYPE_NUM(TYPE_NUM), .TYPE_WIDTH(TYPE_WIDTH),
    .KEY_FILED_NUM(KEY_FILED_NUM), .KEY_OFFSET_WIDTH(KEY_OFFSET_WIDTH),
    .HEAD_SHIFT_WIDTH(HEAD_SHIFT_WIDTH), .META_SHIFT_WIDTH(META_SHIFT_WIDTH),
    .CFG_WIDTH(CFG_WIDTH)
  ) dut (
    .i_clk(clk),
    .i_rst(rst),
    .cfg  (bus.slave)
  );

  task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h t=%0t", nm, act, exp, $time);
    end
  endtask

  function automatic rule_t rand_rule();
    rule_t r;
    r.v  = 1'($urandom_range(0, 1));
    r.td = TD_W'($urandom);
    r.tm = TD_W'($urandom);
    r.ko = KO_W'($urandom);
    r.hs = HEAD_SHIFT_WIDTH'($urandom);
    r.ms = META_SHIFT_WIDTH'($urandom);
    return r;
  endfunction

  function automatic void model_reset();
    cur   = '0;
    map_m = '0;
    for (int i = 0; i < RULE_NUM; i++) tab[i] = '0;
  endfunction

  // Monitor: every cycle that shows an event consumes one scoreboard entry.
  initial begin
    ev_t e;
    forever begin
      @(negedge clk);
      #1;
      if (rst) continue;
      if (bus.o_rule_wren != '0 || bus.o_done || bus.o_err) begin
        chk("done_err_exclusive", {bus.o_done, bus.o_err} == 2'b11, 1'b0);
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_event wren=%0h done=%0b err=%0b t=%0t",
                   bus.o_rule_wren, bus.o_done, bus.o_err, $time);
        end else begin
          e = exp_q.pop_front();
          chk("ev_cycle", 128'(cyc), 128'(e.cyc));
          chk("wren", bus.o_rule_wren, e.wren);
          chk("done", bus.o_done, e.done);
          chk("err", bus.o_err, e.err);
          chk("rule_valid", bus.o_typeRule_valid, e.f.v);
          chk("typeData", bus.o_typeRule_typeData, e.f.td);
          chk("typeMask", bus.o_typeRule_typeMask, e.f.tm);
          chk("keyOffset", bus.o_typeRule_keyOffset, e.f.ko);
          chk("headShift", bus.o_typeRule_headShift, e.f.hs);
          chk("metaShift", bus.o_typeRule_metaShift, e.f.ms);
        end
      end
    end
  end

  // Called at a negedge; returns at the negedge after the word transferred.
  task automatic send(input logic [CFG_WIDTH-1:0] d, output int acc);
    int g;
    g = 0;
    bus.i_cfg_valid = 1'b1;
    bus.i_cfg_data  = d;
    while (!bus.o_cfg_ready && g < 20) begin
      @(negedge clk);
      g++;
    end
    if (g >= 20) begin
      checks++;
      errors++;
      $display("FAIL ready_timeout got=0 exp=1 t=%0t", $time);
    end
    @(negedge clk);
    acc = cyc;
  endtask

  function automatic logic [CFG_WIDTH-1:0] header(input logic [1:0] op, input logic [7:0] idx);
    logic [CFG_WIDTH-1:0] h;
    h = CFG_WIDTH'($urandom);
    h[15:8] = idx;
    h[1:0]  = op;
    return h;
  endfunction

  task automatic push_ev(input int c, input logic [RULE_NUM-1:0] w, input logic d, input logic e);
    ev_t ev;
    ev.cyc = c; ev.wren = w; ev.done = d; ev.err = e; ev.f = cur;
    exp_q.push_back(ev);
  endtask

  task automatic do_write_raw(input logic [7:0] idx, input logic [BUF_W-1:0] rec,
                              input bit keep, output int c);
    rule_t r;
    send(header(2'd0, idx), c);
    for (int w = 0; w < WORDS; w++) send(rec[w*CFG_WIDTH +: CFG_WIDTH], c);
    if (!keep) bus.i_cfg_valid = 1'b0;
    r   = rule_t'(rec[RULE_BITS-1:0]);
    cur = r;
    if (idx < RULE_NUM) begin
      tab[idx]   = r;
      map_m[idx] = r.v;
      push_ev(c, RULE_NUM'(1) << idx, 1'b1, 1'b0);
    end else begin
      push_ev(c, '0, 1'b0, 1'b1);
    end
  endtask

  task automatic do_write(input logic [7:0] idx);
    logic [BUF_W-1:0] rec;
    int c;
    rec = {$urandom, $urandom, $urandom, $urandom};
    rec[RULE_BITS-1:0] = rand_rule();
    do_write_raw(idx, rec, 1'b0, c);
  endtask

  task automatic do_clear();
    int c;
    send(header(2'd1, 8'($urandom)), c);
    bus.i_cfg_valid = 1'b0;
    cur   = '0;
    map_m = '0;
    for (int i = 0; i < RULE_NUM; i++) tab[i] = '0;
    push_ev(c, '1, 1'b1, 1'b0);
  endtask

  task automatic do_bad(input logic [1:0] op, input logic [7:0] idx);
    int c;
    send(header(op, idx), c);
    bus.i_cfg_valid = 1'b0;
    push_ev(c, '0, 1'b0, 1'b1);
  endtask

  task automatic do_read(input logic [7:0] idx);
`ifdef PARSER_CFG_READBACK_EN
    int c, k, g;
    logic [BUF_W-1:0] rec;
    if (idx >= RULE_NUM) begin
      do_bad(2'd2, idx);
    end else begin
      send(header(2'd2, idx), c);
      bus.i_cfg_valid = 1'b0;
      rec = BUF_W'(tab[idx]);
      k = 0;
      g = 0;
      while (k < WORDS && g < 100) begin
        bus.i_rd_ready = 1'($urandom_range(0, 1));
        if (bus.o_rd_valid && bus.i_rd_ready) begin
          chk("rd_word", bus.o_rd_data, rec[k*CFG_WIDTH +: CFG_WIDTH]);
          k++;
        end
        @(negedge clk);
        g++;
      end
      bus.i_rd_ready = 1'b0;
      chk("rd_words_received", 128'(k), 128'(WORDS));
      push_ev(cyc, '0, 1'b1, 1'b0);
    end
`else
    do_bad(2'd2, idx);
`endif
  endtask

  task automatic settle_map();
    bus.i_cfg_valid = 1'b0;
    repeat (2) @(negedge clk);
    chk("valid_map", bus.o_rule_valid_map, map_m);
  endtask

  initial begin
    int c1, c2, g;
    logic [BUF_W-1:0] rec;
    bus.i_cfg_valid = 1'b0;
    bus.i_cfg_data  = '0;
`ifdef PARSER_CFG_READBACK_EN
    bus.i_rd_ready  = 1'b0;
`endif
    model_reset();
    repeat (3) @(negedge clk);
    chk("reset_wren", bus.o_rule_wren, '0);
    rst = 1'b0;
    @(negedge clk);
    chk("reset_ready", bus.o_cfg_ready, 1'b1);
    chk("reset_map", bus.o_rule_valid_map, '0);
    chk("reset_typeData", bus.o_typeRule_typeData, '0);
    chk("reset_done_err", {bus.o_done, bus.o_err}, 2'b00);

    rec = {32'h0000_0000, 32'h0000_0000, 32'hFFFF_0000, 32'h0800_0001};
    do_write_raw(8'd3, rec, 1'b0, c1);
    settle_map();
    chk("tp1_typeData", bus.o_typeRule_typeData, 32'h0400_0000);
    chk("tp1_map", bus.o_rule_valid_map, 8'h08);
    do_read(8'd3);
    settle_map();

    do_write(8'd9);
    settle_map();

    rec = {$urandom, $urandom, $urandom, $urandom};
    do_write_raw(8'd1, rec, 1'b1, c1);
    rec = {$urandom, $urandom, $urandom, $urandom};
    do_write_raw(8'd5, rec, 1'b0, c2);
    chk("b2b_spacing", 128'(c2 - c1), 128'd6);
    settle_map();

    send(header(2'd0, 8'd2), c1);
    send(32'h1234_5677, c1);
    send(32'h9abc_def0, c1);
    bus.i_cfg_valid = 1'b0;
    rst = 1'b1;
    model_reset();
    repeat (2) @(negedge clk);
    chk("rst_mid_wren", bus.o_rule_wren, '0);
    rst = 1'b0;
    @(negedge clk);
    chk("rst_mid_ready", bus.o_cfg_ready, 1'b1);
    chk("rst_mid_map", bus.o_rule_valid_map, '0);
    rec = {$urandom, $urandom, $urandom, $urandom};
    rec[0] = 1'b1;
    do_write_raw(8'd0, rec, 1'b0, c1);
    settle_map();

    rec[0] = 1'b1;
    do_write_raw(8'd3, rec, 1'b0, c1);
    settle_map();
    chk("pre_clear_map", bus.o_rule_valid_map, 8'h09);
    do_clear();
    settle_map();
    chk("post_clear_map", bus.o_rule_valid_map, 8'h00);
    do_bad(2'd3, 8'd1);
    settle_map();

    for (int n = 0; n < 40; n++) begin
      case ($urandom_range(0, 9))
        0, 1, 2, 3, 4, 5: do_write(8'($urandom_range(0, 11)));
        6:                do_clear();
        7, 8:             do_read(8'($urandom_range(0, 10)));
        default:          do_bad(2'd3, 8'($urandom));
      endcase
      if ($urandom_range(0, 1) == 1) settle_map();
      repeat ($urandom_range(0, 2)) @(negedge clk);
    end
    settle_map();

    g = 0;
    while (exp_q.size() != 0 && g < 50) begin
      @(negedge clk);
      g++;
    end
    chk("queue_drained", 128'(exp_q.size()), 128'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
